// File: rtl/eeprom_slave.sv
// Byte-addressed serial EEPROM slave: 2-wire bus with open-drain SDA, 11-bit pointer, and a
// byte-wide internal array. Bus inputs are oversampled on CLK.
module eeprom_slave #(
    parameter logic [3:0]  DEV_ID    = 4'b1010,
    parameter int unsigned MEM_DEPTH = 2048
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCL,
    inout  wire  SDA,
    output logic BUSY,
    output logic WR_STB
);
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW-1:0] LastAddr = AW'(MEM_DEPTH - 1);

    typedef enum logic [3:0] {
        StIdle, StCtrl, StAckCtrl, StAddr, StAckAddr, StWdata, StAckWdata, StRdata, StMack
    } state_e;

    state_e        state_q;
    logic          scl_m_q, scl_s_q, scl_p_q;
    logic          sda_m_q, sda_s_q, sda_p_q;
    logic [3:0]    bit_cnt_q;
    logic [6:0]    shift_q;
    logic [2:0]    addr_hi_q;
    logic [AW-1:0] ptr_q;
    logic          rw_q, phase_q, sda_oe_q, busy_q, wr_stb_q;
    logic [AW-1:0] waddr_q;
    logic [7:0]    wdata_q, rdata_q;
    logic [7:0]    mem [MEM_DEPTH];

    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]    byte_in;
    logic [10:0]   full_addr;
    logic [AW-1:0] ptr_inc;

    // A bus condition needs SCL high on both sides of the SDA edge; otherwise it is a data bit.
    assign scl_rise  = scl_s_q & ~scl_p_q;
    assign scl_fall  = ~scl_s_q & scl_p_q;
    assign start_det = ~sda_s_q & sda_p_q & scl_s_q & scl_p_q;
    assign stop_det  = sda_s_q & ~sda_p_q & scl_s_q & scl_p_q;
    assign byte_in   = {shift_q, sda_s_q};
    assign full_addr = {addr_hi_q, byte_in};
    assign ptr_inc   = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;

    assign SDA    = sda_oe_q ? 1'b0 : 1'bz;
    assign BUSY   = busy_q;
    assign WR_STB = wr_stb_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            scl_m_q   <= 1'b1;
            scl_s_q   <= 1'b1;
            scl_p_q   <= 1'b1;
            sda_m_q   <= 1'b1;
            sda_s_q   <= 1'b1;
            sda_p_q   <= 1'b1;
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_hi_q <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            scl_m_q  <= SCL;
            scl_s_q  <= scl_m_q;
            scl_p_q  <= scl_s_q;
            sda_m_q  <= SDA;
            sda_s_q  <= sda_m_q;
            sda_p_q  <= sda_s_q;
            wr_stb_q <= 1'b0;
            if (stop_det) begin
                state_q   <= StIdle;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else if (start_det) begin
                state_q   <= StCtrl;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StCtrl, StAddr, StWdata: begin
                        if (scl_rise) begin
                            shift_q   <= byte_in[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= '0;
                                phase_q   <= 1'b0;
                                if (state_q == StCtrl) begin
                                    if (byte_in[7:4] == DEV_ID) begin
                                        state_q <= StAckCtrl;
                                        busy_q  <= 1'b1;
                                        rw_q    <= byte_in[0];
                                        if (!byte_in[0]) addr_hi_q <= byte_in[3:1];
                                    end else begin
                                        state_q <= StIdle;
                                        busy_q  <= 1'b0;
                                    end
                                end else if (state_q == StAddr) begin
                                    ptr_q   <= AW'(full_addr);
                                    state_q <= StAckAddr;
                                end else begin
                                    // Commit happens on the 8th rise; the ACK slot follows.
                                    waddr_q  <= ptr_q;
                                    wdata_q  <= byte_in;
                                    wr_stb_q <= 1'b1;
                                    ptr_q    <= ptr_inc;
                                    state_q  <= StAckWdata;
                                end
                            end
                        end
                    end
                    StAckCtrl, StAckAddr, StAckWdata: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end else begin
                                phase_q   <= 1'b0;
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                if (state_q == StAckCtrl && rw_q) begin
                                    state_q  <= StRdata;
                                    rdata_q  <= mem[ptr_q];
                                    sda_oe_q <= ~mem[ptr_q][7];
                                end else if (state_q == StAckCtrl) begin
                                    state_q <= StAddr;
                                end else begin
                                    state_q <= StWdata;
                                end
                            end
                        end
                    end
                    StRdata: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                ptr_q    <= ptr_inc;
                                phase_q  <= 1'b0;
                                state_q  <= StMack;
                            end else begin
                                sda_oe_q <= ~rdata_q[3'(4'd7 - bit_cnt_q)];
                            end
                        end
                    end
                    StMack: begin
                        // Master ACK arms the next byte; it is driven only after SCL falls.
                        if (scl_rise) begin
                            if (sda_s_q) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            phase_q   <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= StRdata;
                            rdata_q   <= mem[ptr_q];
                            sda_oe_q  <= ~mem[ptr_q][7];
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Array is deliberately outside the reset domain so contents survive RESET.
    always_ff @(posedge CLK) begin
        if (wr_stb_q) mem[waddr_q] <= wdata_q;
    end

endmodule

// File: tb/tb_eeprom_slave.sv
// Self-checking bench for eeprom_slave: bus-master tasks, a flat byte-array model with a
// wrapping pointer, directed corner cases, a control-byte table and randomized bursts.
module tb_eeprom_slave;
    localparam int Q     = 25;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda;
    logic busy, wr_stb;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;

    logic [7:0] mem_m [DEPTH];
    int         ptr_m = 0;

    typedef struct {
        logic [7:0] ctrl;
        logic       exp_sda;
        logic       exp_busy;
    } ctrl_vec_t;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;
    always @(posedge clk) if (wr_stb) stb_cnt++;

    eeprom_slave #(.DEV_ID(4'b1010), .MEM_DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RESET (rst),
        .SCL   (scl),
        .SDA   (sda),
        .BUSY  (busy),
        .WR_STB(wr_stb)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void m_write(input logic [7:0] d);
        mem_m[ptr_m] = d;
        ptr_m = (ptr_m + 1) % DEPTH;
    endfunction

    function automatic logic [7:0] m_read();
        logic [7:0] d;
        d = mem_m[ptr_m];
        ptr_m = (ptr_m + 1) % DEPTH;
        return d;
    endfunction

    // Works both from idle (SCL high) and as a repeated START (SCL low).
    task automatic start_c();
        m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0;
    endtask

    task automatic stop_c();
        #Q; m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
    endtask

    task automatic send_bit(input logic b);
        #Q; m_low = ~b; #Q; scl = 1'b1; #(2 * Q); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        #Q; m_low = 1'b0; #Q; scl = 1'b1; #Q; ack = sda; #Q; scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #(2 * Q); scl = 1'b1; #Q; b[i] = sda; #Q; scl = 1'b0;
        end
        #Q; m_low = ~nack; #Q; scl = 1'b1; #(2 * Q); scl = 0; #5; m_low = 1'b0;
    endtask

    task automatic set_addr(input int addr, input string tag);
        logic ack;
        write_byte({4'b1010, 3'(addr >> 8), 1'b0}, ack);
        chk({tag, " wctrl ack"}, int'(ack), 0);
        write_byte(8'(addr), ack);
        chk({tag, " addr ack"}, int'(ack), 0);
        ptr_m = addr % DEPTH;
    endtask

    task automatic write_burst(input int addr, input logic [7:0] data [$], input string tag);
        logic ack;
        int   s0;
        s0 = stb_cnt;
        start_c();
        set_addr(addr, tag);
        foreach (data[i]) begin
            write_byte(data[i], ack);
            chk({tag, " data ack"}, int'(ack), 0);
            m_write(data[i]);
        end
        stop_c();
        #100;
        chk({tag, " wr_stb count"}, stb_cnt - s0, data.size());
        chk({tag, " busy after stop"}, int'(busy), 0);
    endtask

    // use_addr=0 issues a current-address read from the retained pointer.
    task automatic read_burst(input int addr, input int n, input bit use_addr, input string tag);
        logic       ack;
        logic [7:0] b, e;
        start_c();
        if (use_addr) begin
            set_addr(addr, tag);
            start_c();
        end
        write_byte(8'hA1, ack);
        chk({tag, " rctrl ack"}, int'(ack), 0);
        chk({tag, " busy in read"}, int'(busy), 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            e = m_read();
            chk({tag, " read data"}, int'(b), int'(e));
        end
        chk({tag, " busy after nack"}, int'(busy), 0);
        stop_c();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        ctrl_vec_t  tbl [6];
        logic       ack;
        logic [7:0] q [$];
        int         s0;

        tbl = '{'{8'hA0, 1'b0, 1'b1}, '{8'hB0, 1'b1, 1'b0}, '{8'h20, 1'b1, 1'b0},
                '{8'hAE, 1'b0, 1'b1}, '{8'hE2, 1'b1, 1'b0}, '{8'hA8, 1'b0, 1'b1}};

        repeat (5) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset wr_stb", int'(wr_stb), 0);
        chk("reset sda", int'(sda), 1);
        @(negedge clk);
        rst = 1'b0;
        #200;

        // Single byte write at 0x134.
        write_burst(32'h134, '{8'h5A}, "byte write");

        // Random read via write-ctrl, address, repeated START, read-ctrl.
        read_burst(32'h134, 1, 1'b1, "random read");
        chk("random read pointer model", ptr_m, 32'h135);

        // STOP after 4 data bits discards the partial byte.
        s0 = stb_cnt;
        start_c();
        set_addr(32'h134, "partial");
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        stop_c();
        #30;
        chk("partial sda released", int'(sda), 1);
        #100;
        chk("partial no wr_stb", stb_cnt - s0, 0);
        chk("partial busy", int'(busy), 0);
        read_burst(32'h134, 1, 1'b1, "partial readback");

        // Pointer wrap on write and on read.
        write_burst(32'h7FF, '{8'h11, 8'h22}, "wrap write");
        read_burst(32'h7FF, 2, 1'b1, "wrap read");
        chk("wrap mem0 model", int'(mem_m[0]), 8'h22);

        // Control-byte table: device-ID match decides ACK and BUSY.
        for (int i = 0; i < 6; i++) begin
            start_c();
            write_byte(tbl[i].ctrl, ack);
            chk($sformatf("ctrl 0x%02h ack", tbl[i].ctrl), int'(ack), int'(tbl[i].exp_sda));
            chk($sformatf("ctrl 0x%02h busy", tbl[i].ctrl), int'(busy), int'(tbl[i].exp_busy));
            stop_c();
            #40;
            chk($sformatf("ctrl 0x%02h busy after stop", tbl[i].ctrl), int'(busy), 0);
        end

        // RESET while the slave drives the MSB (0) of 0x5A.
        start_c();
        set_addr(32'h134, "reset");
        start_c();
        write_byte(8'hA3, ack);
        chk("reset rctrl ack", int'(ack), 0);
        #40;
        chk("reset rdata drives msb", int'(sda), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset mid-read sda", int'(sda), 1);
        chk("reset mid-read busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        stop_c();
        read_burst(0, 1, 1'b0, "after reset read ptr0");

        // Randomized bursts, including ones that straddle the wrap point.
        for (int it = 0; it < 8; it++) begin
            int addr;
            int n;
            addr = (it % 3 == 0) ? int'($urandom_range(DEPTH - 3, DEPTH - 1))
                                 : int'($urandom_range(0, DEPTH - 1));
            n = int'($urandom_range(1, 4));
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            write_burst(addr, q, $sformatf("rand%0d write", it));
            read_burst(addr, n, 1'b1, $sformatf("rand%0d read", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
